// File: rtl/cmos_capture_pkg.sv
// Shared types and widths for the CMOS DVP capture block.
// The optional status counters are compiled in with CMOS_CAPTURE_STATUS_EN.
package cmos_capture_pkg;

  localparam int PIX_W       = 16;
  localparam int BYTE_W      = 8;
  localparam int SKIP_CNT_W  = 8;
  localparam int PIX_CNT_W   = 12;
  localparam int LINE_CNT_W  = 12;
  localparam int FRAME_CNT_W = 16;

  // SKIP: discarding start-up frames; ALIGN: waiting for a clean frame start;
  // CAPTURE: producing pixels until the next reset.
  typedef enum logic [1:0] {
    SKIP    = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/cmos_byte_pack.sv
// Packs pairs of sensor bytes into RGB565 pixels.
// The first byte of a pair is the high byte. Any gap in href discards a
// half-collected pixel, so odd-length lines drop their last byte silently.
module cmos_byte_pack
  import cmos_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              href,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data
);

  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] high_q, high_d;
  logic              pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;

  // Byte-phase tracking and pixel assembly; pixel data only moves on a strobe.
  always_comb begin
    phase_d     = 1'b0;
    high_d      = high_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    if (enable && href) begin
      if (!phase_q) begin
        high_d  = byte_in;
        phase_d = 1'b1;
      end else begin
        pix_valid_d = 1'b1;
        pix_data_d  = {high_q, byte_in};
      end
    end
  end

  // Packer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= 1'b0;
      high_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      high_q      <= high_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: rtl/cmos_dvp_capture.sv
// CMOS DVP sensor capture: registers the sensor pins, skips SKIP_FRAMES frames
// after reset, aligns to a frame start and then emits RGB565 pixels with
// native blank/sync timing. Define CMOS_CAPTURE_STATUS_EN to add the
// pixel_count / line_count / frame_count status outputs.
// Handshake: vid_active_video is a one-cycle strobe with no back-pressure;
// vid_data is valid on the strobe and holds until the next one.
module cmos_dvp_capture
  import cmos_capture_pkg::*;
#(
  parameter int SKIP_FRAMES       = 10,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic                   cmos_pclk,
  input  logic                   rst,
  input  logic                   cmos_vsync,
  input  logic                   cmos_href,
  input  logic [BYTE_W-1:0]      cmos_d,
  output logic                   vid_active_video,
  output logic [PIX_W-1:0]       vid_data,
  output logic                   vid_hblank,
  output logic                   vid_hsync,
  output logic                   vid_vblank,
  output logic                   vid_vsync,
  output logic                   frame_skip_done,
`ifdef CMOS_CAPTURE_STATUS_EN
  output logic [PIX_CNT_W-1:0]   pixel_count,
  output logic [LINE_CNT_W-1:0]  line_count,
  output logic [FRAME_CNT_W-1:0] frame_count,
`endif
  output cap_state_e             dbg_state
);

  localparam logic [SKIP_CNT_W-1:0] SKIP_CNT = SKIP_CNT_W'(SKIP_FRAMES);

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [BYTE_W-1:0] dat_q, dat_d;
  logic              vs_prev_q, vs_prev_d;
  logic              vs_n, vs_fall, line_valid;

  cap_state_e           state_q, state_d;
  logic [SKIP_CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic                 seen_q, seen_d;
  logic                 capture_en;

  logic hblank_q, hblank_d;
  logic vblank_q, vblank_d;
  logic pix_valid;

  // Input capture: every sensor pin passes through one flop before use.
  always_comb begin
    vsync_d   = cmos_vsync;
    href_d    = cmos_href;
    dat_d     = cmos_d;
    vs_prev_d = vs_n;
  end

  // Input registers; vsync resets to its inactive level so no false edge.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      vsync_q   <= ~VSYNC_ACTIVE_HIGH;
      href_q    <= 1'b0;
      dat_q     <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      dat_q     <= dat_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign vs_n       = VSYNC_ACTIVE_HIGH ? vsync_q : ~vsync_q;
  assign vs_fall    = vs_prev_q & ~vs_n;
  assign line_valid = href_q & ~vs_n;

  // FSM state register with skip counter and align "vsync seen" flag.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state_q    <= SKIP;
      skip_cnt_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      seen_q     <= seen_d;
    end
  end

  // FSM next state: count vsync falls, then wait for a full vsync pulse.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    seen_d     = seen_q;
    case (state_q)
      SKIP: begin
        if (skip_cnt_q == SKIP_CNT) state_d = ALIGN;
        else if (vs_fall)           skip_cnt_d = skip_cnt_q + SKIP_CNT_W'(1);
      end
      ALIGN: begin
        if (vs_n) seen_d = 1'b1;
        if (seen_q && vs_fall) state_d = CAPTURE;
      end
      CAPTURE: state_d = CAPTURE;
      default: state_d = SKIP;
    endcase
  end

  // FSM outputs.
  always_comb begin
    capture_en      = (state_q == CAPTURE);
    frame_skip_done = (state_q != SKIP);
  end

  assign dbg_state = state_q;

  cmos_byte_pack u_pack (
    .clk       (cmos_pclk),
    .rst       (rst),
    .enable    (capture_en),
    .href      (line_valid),
    .byte_in   (dat_q),
    .pix_valid (pix_valid),
    .pix_data  (vid_data)
  );

  // Timing outputs follow the registered pins one cycle later, forced idle
  // outside capture.
  always_comb begin
    hblank_d = capture_en ? ~href_q : 1'b1;
    vblank_d = capture_en ? vs_n : 1'b1;
  end

  // Timing output registers.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
    end else begin
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
    end
  end

  assign vid_active_video = pix_valid;
  assign vid_hblank       = hblank_q;
  assign vid_hsync        = hblank_q;
  assign vid_vblank       = vblank_q;
  assign vid_vsync        = vblank_q;

`ifdef CMOS_CAPTURE_STATUS_EN
  logic                   lv_q, lv_d;
  logic                   line_end, vs_rise;
  logic [PIX_CNT_W-1:0]   pix_run_q, pix_run_d, width_q, width_d;
  logic [LINE_CNT_W-1:0]  line_run_q, line_run_d, lines_q, lines_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  // The last pixel strobe of a line lands in the same cycle as the line end.
  assign line_end = lv_q & ~line_valid;
  assign vs_rise  = ~vs_prev_q & vs_n;

  // Status counters: line width, lines per frame, captured frames.
  always_comb begin
    lv_d       = line_valid;
    pix_run_d  = pix_run_q;
    width_d    = width_q;
    line_run_d = line_run_q;
    lines_d    = lines_q;
    frames_d   = frames_q;
    if (capture_en) begin
      if (line_end) begin
        width_d    = pix_run_q + PIX_CNT_W'(pix_valid);
        pix_run_d  = '0;
        line_run_d = line_run_q + LINE_CNT_W'(1);
      end else if (pix_valid) begin
        pix_run_d = pix_run_q + PIX_CNT_W'(1);
      end
      if (vs_rise) begin
        lines_d    = line_run_q + LINE_CNT_W'(line_end);
        line_run_d = '0;
        frames_d   = frames_q + FRAME_CNT_W'(1);
      end
    end
  end

  // Status counter registers.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      lv_q       <= 1'b0;
      pix_run_q  <= '0;
      width_q    <= '0;
      line_run_q <= '0;
      lines_q    <= '0;
      frames_q   <= '0;
    end else begin
      lv_q       <= lv_d;
      pix_run_q  <= pix_run_d;
      width_q    <= width_d;
      line_run_q <= line_run_d;
      lines_q    <= lines_d;
      frames_q   <= frames_d;
    end
  end

  assign pixel_count = width_q;
  assign line_count  = lines_q;
  assign frame_count = frames_q;
`endif

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Bench for cmos_dvp_capture: three instances share one sensor stimulus
// (skip 2 active-high, skip 2 active-low, skip 1 active-high) and each is
// scored against a frame/pair model of the expected pixel stream.
module tb_cmos_dvp_capture;
  import cmos_capture_pkg::*;

  localparam int SKIP_A = 2;
  localparam int SKIP_B = 2;
  localparam int SKIP_C = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       vs_pin, href_pin, vs_pin_n;
  logic [7:0] d_pin;
  assign vs_pin_n = ~vs_pin;

  logic        act_a, act_b, act_c;
  logic [15:0] data_a, data_b, data_c;
  logic        hb_a, hs_a, vb_a, vsy_a, done_a;
  logic        hb_b, hs_b, vb_b, vsy_b, done_b;
  logic        hb_c, hs_c, vb_c, vsy_c, done_c;
  cap_state_e  st_a, st_b, st_c;
`ifdef CMOS_CAPTURE_STATUS_EN
  logic [11:0] pc_a, lc_a, pc_b, lc_b, pc_c, lc_c;
  logic [15:0] fc_a, fc_b, fc_c;
`endif

  cmos_dvp_capture #(.SKIP_FRAMES(SKIP_A), .VSYNC_ACTIVE_HIGH(1'b1)) dut_a (
    .cmos_pclk(clk), .rst(rst), .cmos_vsync(vs_pin), .cmos_href(href_pin), .cmos_d(d_pin),
    .vid_active_video(act_a), .vid_data(data_a), .vid_hblank(hb_a), .vid_hsync(hs_a),
    .vid_vblank(vb_a), .vid_vsync(vsy_a), .frame_skip_done(done_a),
`ifdef CMOS_CAPTURE_STATUS_EN
    .pixel_count(pc_a), .line_count(lc_a), .frame_count(fc_a),
`endif
    .dbg_state(st_a));

  cmos_dvp_capture #(.SKIP_FRAMES(SKIP_B), .VSYNC_ACTIVE_HIGH(1'b0)) dut_b (
    .cmos_pclk(clk), .rst(rst), .cmos_vsync(vs_pin_n), .cmos_href(href_pin), .cmos_d(d_pin),
    .vid_active_video(act_b), .vid_data(data_b), .vid_hblank(hb_b), .vid_hsync(hs_b),
    .vid_vblank(vb_b), .vid_vsync(vsy_b), .frame_skip_done(done_b),
`ifdef CMOS_CAPTURE_STATUS_EN
    .pixel_count(pc_b), .line_count(lc_b), .frame_count(fc_b),
`endif
    .dbg_state(st_b));

  cmos_dvp_capture #(.SKIP_FRAMES(SKIP_C), .VSYNC_ACTIVE_HIGH(1'b1)) dut_c (
    .cmos_pclk(clk), .rst(rst), .cmos_vsync(vs_pin), .cmos_href(href_pin), .cmos_d(d_pin),
    .vid_active_video(act_c), .vid_data(data_c), .vid_hblank(hb_c), .vid_hsync(hs_c),
    .vid_vblank(vb_c), .vid_vsync(vsy_c), .frame_skip_done(done_c),
`ifdef CMOS_CAPTURE_STATUS_EN
    .pixel_count(pc_c), .line_count(lc_c), .frame_count(fc_c),
`endif
    .dbg_state(st_c));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [47:0] exp_a[$], exp_b[$], exp_c[$];   // {cycle, pixel}
  logic [47:0] ea, eb, ec;
  logic [15:0] last_a, last_b, last_c;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int frame_idx = 0;
  int fcnt_a = 0;
  logic [7:0] line_buf[$];

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (act_a) begin
        cnt_a++;
        if (exp_a.size() == 0) begin
          bad++; $display("FAIL pix_a unexpected got=%h at cyc %0d want=none", data_a, cyc);
        end else begin
          ea = exp_a.pop_front();
          if (data_a !== ea[15:0] || cyc != int'(ea[47:16]) || hb_a !== 1'b0 || vb_a !== 1'b0) begin
            bad++; $display("FAIL pix_a got=%h@%0d hb=%b vb=%b want=%h@%0d hb=0 vb=0", data_a, cyc, hb_a, vb_a, ea[15:0], ea[47:16]);
          end
        end
      end else if (data_a !== last_a) begin
        bad++; $display("FAIL hold_a got=%h want=%h", data_a, last_a);
      end
    end
    last_a = data_a;
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (act_b) begin
        cnt_b++;
        if (exp_b.size() == 0) begin
          bad++; $display("FAIL pix_b unexpected got=%h at cyc %0d want=none", data_b, cyc);
        end else begin
          eb = exp_b.pop_front();
          if (data_b !== eb[15:0] || cyc != int'(eb[47:16]) || hb_b !== 1'b0 || vb_b !== 1'b0) begin
            bad++; $display("FAIL pix_b got=%h@%0d hb=%b vb=%b want=%h@%0d hb=0 vb=0", data_b, cyc, hb_b, vb_b, eb[15:0], eb[47:16]);
          end
        end
      end else if (data_b !== last_b) begin
        bad++; $display("FAIL hold_b got=%h want=%h", data_b, last_b);
      end
    end
    last_b = data_b;
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (act_c) begin
        cnt_c++;
        if (exp_c.size() == 0) begin
          bad++; $display("FAIL pix_c unexpected got=%h at cyc %0d want=none", data_c, cyc);
        end else begin
          ec = exp_c.pop_front();
          if (data_c !== ec[15:0] || cyc != int'(ec[47:16]) || hb_c !== 1'b0 || vb_c !== 1'b0) begin
            bad++; $display("FAIL pix_c got=%h@%0d hb=%b vb=%b want=%h@%0d hb=0 vb=0", data_c, cyc, hb_c, vb_c, ec[15:0], ec[47:16]);
          end
        end
      end else if (data_c !== last_c) begin
        bad++; $display("FAIL hold_c got=%h want=%h", data_c, last_c);
      end
    end
    last_c = data_c;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vsync pulse (href may be garbage during it) followed by a short gap.
  task automatic start_frame();
    logic exp_done_a, exp_done_b, exp_done_c;
    frame_idx++;
    exp_done_a = (frame_idx - 1 >= SKIP_A);
    exp_done_b = (frame_idx - 1 >= SKIP_B);
    exp_done_c = (frame_idx - 1 >= SKIP_C);
    total++;
    if (done_a !== exp_done_a || done_b !== exp_done_b || done_c !== exp_done_c) begin
      bad++; $display("FAIL skip_done frame %0d got=%b%b%b want=%b%b%b", frame_idx,
                      done_a, done_b, done_c, exp_done_a, exp_done_b, exp_done_c);
    end
    if (frame_idx > SKIP_A + 1) fcnt_a++;
    for (int i = 0; i < 3; i++) begin
      tick(); vs_pin = 1'b1; href_pin = 1'($urandom_range(0, 1)); d_pin = 8'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); vs_pin = 1'b0; href_pin = 1'b0; d_pin = 8'($urandom);
    end
  endtask

  // Sends line_buf as one href-high line and records the expected pixels.
  task automatic send_line();
    logic [7:0] hi;
    logic cap_a, cap_b, cap_c;
    int n;
    n = line_buf.size();
    hi = 8'h00;
    cap_a = (frame_idx > SKIP_A);
    cap_b = (frame_idx > SKIP_B);
    cap_c = (frame_idx > SKIP_C);
    for (int i = 0; i < n; i++) begin
      tick(); href_pin = 1'b1; d_pin = line_buf[i];
      if (i % 2 == 1) begin
        if (cap_a) exp_a.push_back({32'(cyc + 2), hi, line_buf[i]});
        if (cap_b) exp_b.push_back({32'(cyc + 2), hi, line_buf[i]});
        if (cap_c) exp_c.push_back({32'(cyc + 2), hi, line_buf[i]});
      end else begin
        hi = line_buf[i];
      end
      if (i == 2) begin
        total++;
        if (hb_a !== ~cap_a || vb_a !== ~cap_a || hb_b !== ~cap_b || vb_b !== ~cap_b ||
            hb_c !== ~cap_c || vb_c !== ~cap_c) begin
          bad++; $display("FAIL mid_line_blank frame %0d got=%b%b %b%b %b%b want=%b%b %b%b %b%b", frame_idx,
                          hb_a, vb_a, hb_b, vb_b, hb_c, vb_c, ~cap_a, ~cap_a, ~cap_b, ~cap_b, ~cap_c, ~cap_c);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(); href_pin = 1'b0; d_pin = 8'($urandom);
    end
    line_buf.delete();
  endtask

  // len == 0 gives random line lengths 1..12.
  task automatic run_frame(input int lines, input int len);
    start_frame();
    for (int l = 0; l < lines; l++) begin
      int n;
      n = (len > 0) ? len : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) line_buf.push_back(8'($urandom));
      send_line();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) begin
      tick(); href_pin = 1'b0; vs_pin = 1'b0;
    end
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || exp_c.size() != 0) begin
      bad++; $display("FAIL %s missing pixels got=%0d/%0d/%0d want=0/0/0", tag,
                      exp_a.size(), exp_b.size(), exp_c.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; vs_pin = 1'b0; href_pin = 1'b0; d_pin = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (data_a !== 16'h0000 || act_a !== 1'b0) begin
      bad++; $display("FAIL reset_data got=%h/%b want=0000/0", data_a, act_a);
    end
    total++;
    if (hb_a !== 1'b1 || hs_a !== 1'b1 || vb_a !== 1'b1 || vsy_a !== 1'b1) begin
      bad++; $display("FAIL reset_timing_a got=%b%b%b%b want=1111", hb_a, hs_a, vb_a, vsy_a);
    end
    total++;
    if (hb_b !== 1'b1 || vb_b !== 1'b1 || hb_c !== 1'b1 || vb_c !== 1'b1) begin
      bad++; $display("FAIL reset_timing_bc got=%b%b%b%b want=1111", hb_b, vb_b, hb_c, vb_c);
    end
    total++;
    if (done_a !== 1'b0 || done_b !== 1'b0 || done_c !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b%b%b want=000", done_a, done_b, done_c);
    end
    total++;
    if (st_a !== SKIP || st_b !== SKIP || st_c !== SKIP) begin
      bad++; $display("FAIL reset_state got=%0d/%0d/%0d want=0", st_a, st_b, st_c);
    end
    rst = 1'b0;
    frame_idx = 0;
    fcnt_a = 0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_skip();
    for (int f = 0; f < 4; f++) run_frame(4, 8);
    drain("skip");
    total++;
    if (cnt_a != 32 || cnt_b != 32 || cnt_c != 48) begin
      bad++; $display("FAIL skip_strobes got=%0d/%0d/%0d want=32/32/48", cnt_a, cnt_b, cnt_c);
    end
  endtask

  task automatic test_pixels();
    start_frame();
    line_buf.push_back(8'hF8); line_buf.push_back(8'h00);
    line_buf.push_back(8'h07); line_buf.push_back(8'hE0);
    send_line();
    for (int i = 0; i < 7; i++) line_buf.push_back(8'($urandom));
    send_line();
    line_buf.push_back(8'h12); line_buf.push_back(8'h34);
    send_line();
    drain("pixels");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(1, 5)), 0);
    drain("random");
  endtask

`ifdef CMOS_CAPTURE_STATUS_EN
  task automatic test_status();
    for (int f = 0; f < 3; f++) begin
      start_frame();
      total++;
      if (fc_a !== 16'(fcnt_a)) begin
        bad++; $display("FAIL frame_count got=%0d want=%0d", fc_a, fcnt_a);
      end
      if (f > 0) begin
        total++;
        if (pc_a !== 12'd640 || lc_a !== 12'd4) begin
          bad++; $display("FAIL line_status got=%0d/%0d want=640/4", pc_a, lc_a);
        end
      end
      for (int l = 0; l < 4; l++) begin
        for (int i = 0; i < 1280; i++) line_buf.push_back(8'($urandom));
        send_line();
      end
    end
    drain("status");
  endtask
`endif

  task automatic test_reset_mid();
    start_frame();
    tick(); href_pin = 1'b1; d_pin = 8'hA5;
    tick(); d_pin = 8'h5A;
    exp_a.push_back({32'(cyc + 2), 16'hA55A});
    exp_b.push_back({32'(cyc + 2), 16'hA55A});
    exp_c.push_back({32'(cyc + 2), 16'hA55A});
    tick(); d_pin = 8'hC3;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (data_a !== 16'h0000 || act_a !== 1'b0 || hb_a !== 1'b1 || vb_a !== 1'b1 || done_a !== 1'b0) begin
      bad++; $display("FAIL mid_reset_outputs got=%h %b%b%b%b want=0000 0110", data_a, act_a, hb_a, vb_a, done_a);
    end
    total++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || exp_c.size() != 0) begin
      bad++; $display("FAIL mid_reset_pending got=%0d/%0d/%0d want=0/0/0", exp_a.size(), exp_b.size(), exp_c.size());
    end
    href_pin = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    frame_idx = 0;
    fcnt_a = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 3; i++) tick();
    run_frame(2, 6);
    total++;
    if (cnt_a != 0 || cnt_b != 0 || cnt_c != 0) begin
      bad++; $display("FAIL post_reset_early got=%0d/%0d/%0d want=0/0/0", cnt_a, cnt_b, cnt_c);
    end
    run_frame(2, 6);
    run_frame(2, 6);
    drain("reset_mid");
    total++;
    if (cnt_a != 6 || cnt_c != 12) begin
      bad++; $display("FAIL post_reset_strobes got=%0d/%0d want=6/12", cnt_a, cnt_c);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_skip();
    test_pixels();
    test_random();
`ifdef CMOS_CAPTURE_STATUS_EN
    test_status();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc %0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
